// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - instruction issue and write-back front end for the 3-bit-opcode execute unit
module instr_issue_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_instr,
  input  logic        load_en,
  input  logic [1:0]  load_addr,
  input  logic [3:0]  load_data,
  output logic [3:0]  ex_rs,
  output logic [3:0]  ex_rt,
  output logic [2:0]  ex_sel,
  input  logic [3:0]  ex_rd,
  output logic        wb_valid,
  output logic [1:0]  wb_addr,
  output logic [3:0]  wb_data,
  output logic        busy,
  output logic [15:0] rf_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_rf [4];
  logic [3:0] r_ex_rs;
  logic [3:0] r_ex_rt;
  logic [2:0] r_ex_sel;
  logic [1:0] r_dst;
  logic       r_wb_valid;
  logic [1:0] r_wb_addr;
  logic [3:0] r_wb_data;

  logic [2:0] w_op;
  logic [1:0] w_dst;
  logic [1:0] w_src_s;
  logic [1:0] w_src_t;
  logic       w_idle;
  logic       w_accept;

  assign w_op    = in_instr[8:6];
  assign w_dst   = in_instr[5:4];
  assign w_src_s = in_instr[3:2];
  assign w_src_t = in_instr[1:0];

  // A preload in IDLE wins over an offered instruction, so it blocks acceptance.
  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && !load_en && in_valid;
  assign in_ready = w_idle && !load_en && !rst;
  assign busy     = !w_idle;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: accept -> one execute cycle -> one write-back cycle -> idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are read once at accept and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rs  <= 4'h0;
      r_ex_rt  <= 4'h0;
      r_ex_sel <= 3'h0;
      r_dst    <= 2'h0;
    end else if (w_accept) begin
      r_ex_rs  <= r_rf[w_src_s];
      r_ex_rt  <= r_rf[w_src_t];
      r_ex_sel <= w_op;
      r_dst    <= w_dst;
    end
  end

  // Capture the execute result at the end of EXEC; the pulse lasts the WB cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= 2'h0;
      r_wb_data  <= 4'h0;
    end else if (r_state == S_EXEC) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= r_dst;
      r_wb_data  <= ex_rd;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  // Register file: preload only in IDLE, write-back only in WB, so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_rf[i] <= 4'h0;
    end else if (w_idle && load_en) begin
      r_rf[load_addr] <= load_data;
    end else if (r_state == S_WB) begin
      r_rf[r_wb_addr] <= r_wb_data;
    end
  end

  assign ex_rs    = r_ex_rs;
  assign ex_rt    = r_ex_rt;
  assign ex_sel   = r_ex_sel;
  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;
  assign rf_dbg   = {r_rf[3], r_rf[2], r_rf[1], r_rf[0]};

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - self-checking bench for instr_issue_unit
module tb_instr_issue_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_instr;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [3:0]  load_data;
  logic [3:0]  ex_rs;
  logic [3:0]  ex_rt;
  logic [2:0]  ex_sel;
  logic [3:0]  ex_rd;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [3:0]  wb_data;
  logic        busy;
  logic [15:0] rf_dbg;

  int n_checks;
  int n_errors;

  logic [3:0] ref_rf [4];

  instr_issue_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_sel(ex_sel), .ex_rd(ex_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .rf_dbg(rf_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in execute unit: SUB, ADD and a few logic ops, 4-bit wrap.
  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    case (sel)
      3'd0: alu = a - b;
      3'd1: alu = a + b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = ~a;
      3'd6: alu = a;
      default: alu = b;
    endcase
  endfunction

  assign ex_rd = alu(ex_rs, ex_rt, ex_sel);

  function automatic logic [15:0] packed_rf();
    return {ref_rf[3], ref_rf[2], ref_rf[1], ref_rf[0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [1:0] a, input logic [3:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    ref_rf[a] = d;
    check("preload_rf", rf_dbg, packed_rf());
    check("preload_busy", {15'h0, busy}, 16'h0);
  endtask

  // Called at the negedge just before the accepting edge, with in_valid already high.
  task automatic run_accepted(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s,
                              input logic [1:0] t, input bit ld_exec, output logic [3:0] got);
    logic [3:0] exp;
    exp = alu(ref_rf[s], ref_rf[t], op);
    @(negedge clk);
    in_valid = 1'b0;
    check("ex_rs", {12'h0, ex_rs}, {12'h0, ref_rf[s]});
    check("ex_rt", {12'h0, ex_rt}, {12'h0, ref_rf[t]});
    check("ex_sel", {13'h0, ex_sel}, {13'h0, op});
    check("exec_busy", {15'h0, busy}, 16'h1);
    check("exec_ready", {15'h0, in_ready}, 16'h0);
    if (ld_exec) begin
      load_en = 1'b1; load_addr = 2'($urandom); load_data = 4'($urandom);
    end
    @(negedge clk);
    load_en = 1'b0;
    check("wb_valid_hi", {15'h0, wb_valid}, 16'h1);
    check("wb_addr", {14'h0, wb_addr}, {14'h0, d});
    check("wb_data", {12'h0, wb_data}, {12'h0, exp});
    check("rf_hold", rf_dbg, packed_rf());
    got = wb_data;
    ref_rf[d] = exp;
    @(negedge clk);
    check("wb_valid_lo", {15'h0, wb_valid}, 16'h0);
    check("rf_after_wb", rf_dbg, packed_rf());
    check("idle_ready", {15'h0, in_ready}, 16'h1);
    check("idle_busy", {15'h0, busy}, 16'h0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s,
                       input logic [1:0] t, input bit ld_exec, output logic [3:0] got);
    int waited;
    in_valid = 1'b1;
    in_instr = {op, d, s, t};
    #1;
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk); #1;
      waited++;
    end
    check("accept_ready", {15'h0, in_ready}, 16'h1);
    run_accepted(op, d, s, t, ld_exec, got);
  endtask

  initial begin
    logic [3:0] got;
    int accepts [$];
    logic [3:0] wbs [$];
    n_checks = 0; n_errors = 0;
    rst = 1'b0; in_valid = 1'b0; in_instr = 9'h0;
    load_en = 1'b0; load_addr = 2'h0; load_data = 4'h0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 4'h0;

    // Reset with random inputs.
    #2 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_instr = 9'($urandom);
      load_en = 1'($urandom); load_addr = 2'($urandom); load_data = 4'($urandom);
      #1;
      check("rst_rf", rf_dbg, 16'h0);
      check("rst_ex", {5'h0, ex_rs, ex_rt, ex_sel}, 16'h0);
      check("rst_wb", {9'h0, wb_valid, wb_addr, wb_data}, 16'h0);
      check("rst_ready", {15'h0, in_ready}, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; load_en = 1'b0;
    #1;
    check("post_rst_ready", {15'h0, in_ready}, 16'h1);
    check("post_rst_busy", {15'h0, busy}, 16'h0);
    @(negedge clk);

    // ADD R3 = R1 + R2.
    preload(2'd1, 4'd3);
    preload(2'd2, 4'd5);
    issue(3'd1, 2'd3, 2'd1, 2'd2, 1'b0, got);
    check("add_wb", {12'h0, got}, 16'h8);
    check("add_r3", {12'h0, rf_dbg[15:12]}, 16'h8);

    // SUB R0 = R1 - R2 wraps.
    issue(3'd0, 2'd0, 2'd1, 2'd2, 1'b0, got);
    check("sub_wb", {12'h0, got}, 16'hE);
    check("sub_r0", {12'h0, rf_dbg[3:0]}, 16'hE);

    // Back-to-back ADD R1,R1,R1 with in_valid held.
    preload(2'd1, 4'd3);
    in_valid = 1'b1;
    in_instr = {3'd1, 2'd1, 2'd1, 2'd1};
    #1;
    for (int i = 0; i < 6; i++) begin
      if (in_valid && in_ready) accepts.push_back(i);
      if (wb_valid) wbs.push_back(wb_data);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_accepts", 16'(accepts.size()), 16'd2);
    if (accepts.size() == 2) check("b2b_spacing", 16'(accepts[1] - accepts[0]), 16'd3);
    check("b2b_wbs", 16'(wbs.size()), 16'd2);
    if (wbs.size() == 2) begin
      check("b2b_wb0", {12'h0, wbs[0]}, 16'h6);
      check("b2b_wb1", {12'h0, wbs[1]}, 16'hC);
    end
    ref_rf[1] = 4'hC;
    check("b2b_rf", rf_dbg, packed_rf());

    // Load priority over a simultaneous instruction.
    load_en = 1'b1; load_addr = 2'd2; load_data = 4'd7;
    in_valid = 1'b1; in_instr = {3'd1, 2'd3, 2'd2, 2'd0};
    #1;
    check("prio_ready", {15'h0, in_ready}, 16'h0);
    @(negedge clk);
    load_en = 1'b0;
    ref_rf[2] = 4'd7;
    #1;
    check("prio_rf", rf_dbg, packed_rf());
    check("prio_busy", {15'h0, busy}, 16'h0);
    check("prio_ready2", {15'h0, in_ready}, 16'h1);
    run_accepted(3'd1, 2'd3, 2'd2, 2'd0, 1'b1, got);
    check("prio_rs", {12'h0, ex_rs}, 16'h7);

    // Reset during WB drops the write-back.
    in_valid = 1'b1; in_instr = {3'd1, 2'd2, 2'd1, 2'd1};
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_wb_valid", {15'h0, wb_valid}, 16'h1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) ref_rf[i] = 4'h0;
    check("mid_wb_drop", {15'h0, wb_valid}, 16'h0);
    check("mid_rf", rf_dbg, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_idle_busy", {15'h0, busy}, 16'h0);
    check("mid_idle_ready", {15'h0, in_ready}, 16'h1);
    @(negedge clk);
    check("mid_rf_after", rf_dbg, 16'h0);

    // Randomized mix of preloads and instructions against the register model.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        preload(2'($urandom), 4'($urandom));
      else
        issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), got);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
